sys_nios2_qsys_0_oci_dct_packer: RTL and testbench

//  Producer side of the OCI direct-control-transfer (DCT) trace path. Packs 2-bit DCT codes
//  (one per retired conditional branch) into the 30-bit dct_buffer / 4-bit dct_count pair.

---
 rtl/oci_trace_pkg.sv | 30 +++
 rtl/oci_frame_skid.sv | 45 ++++
 rtl/sys_nios2_qsys_0_oci_dct_packer.sv | 123 ++++++++++++
 tb/tb_sys_nios2_qsys_0_oci_dct_packer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/oci_trace_pkg.sv
// Shared types and constants for OCI trace producers (DCT packer and friends).
package oci_trace_pkg;

  localparam int DCT_SLOTS = 15;
  localparam int BUF_W     = 2 * DCT_SLOTS;
  localparam int CNT_W     = 4;
  localparam int FRAME_W   = 36;

  localparam logic [1:0] FRAME_TYPE_DCT = 2'b10;

  typedef enum logic [1:0] {
    DCT_NOT_TAKEN = 2'b00,
    DCT_TAKEN     = 2'b01,
    DCT_EXCEPTION = 2'b10,
    DCT_RESERVED  = 2'b11
  } dct_code_e;

  typedef enum logic [1:0] {
    ST_PACK  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } trace_state_e;

  function automatic logic [FRAME_W-1:0] pack_frame(input logic [1:0]       frame_type,
                                                     input logic [CNT_W-1:0] count,
                                                     input logic [BUF_W-1:0] buffer);
    return {frame_type, count, buffer};
  endfunction

endpackage

// File: rtl/oci_frame_skid.sv
// Single-entry valid/ready output register; frees in the same cycle it is drained.
module oci_frame_skid
  import oci_trace_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sys_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit DCT branch codes into 15-slot buffers and emits them as 36-bit trace frames,
// with an end-of-test drain sequence for the OCI monitor.
module sys_nios2_qsys_0_oci_dct_packer
  import oci_trace_pkg::*;
#(
  parameter logic [1:0] FRAME_TYPE = FRAME_TYPE_DCT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dct_valid,
  input  logic [1:0]         dct_code,
  output logic               dct_ready,
  input  logic               flush,
  input  logic               end_req,
  output logic               frame_valid,
  output logic [FRAME_W-1:0] frame_data,
  input  logic               frame_ready,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               test_ending,
  output logic               test_has_ended,
  output logic [15:0]        drop_count
);

  trace_state_e       state_q, state_d;
  logic [BUF_W-1:0]   buffer_q, buffer_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               flush_pend_q, flush_pend_d;
  logic               test_ending_q, test_ending_d;
  logic               test_has_ended_q, test_has_ended_d;
  logic [15:0]        drop_count_q, drop_count_d;

  logic               out_free;
  logic               flush_req;
  logic               emit_pending;
  logic               accept;
  logic               want_emit;
  logic               emit;
  logic [BUF_W-1:0]   buf_next;
  logic [CNT_W-1:0]   cnt_next;

  assign flush_req    = flush | flush_pend_q;
  assign emit_pending = (count_q == 4'd14) | flush_req;
  assign dct_ready    = ~test_has_ended_q & ~test_ending_q &
                        ~(frame_valid & ~frame_ready & emit_pending);
  assign accept       = dct_valid & dct_ready;

  always_comb begin
    buf_next = buffer_q;
    for (int i = 0; i < DCT_SLOTS; i++) begin
      if (accept && count_q == CNT_W'(i)) buf_next[2*i +: 2] = dct_code;
    end
    cnt_next = count_q + CNT_W'(accept);
  end

  // A buffer only leaves when the output register can take it this cycle; an empty
  // buffer never produces a frame.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = 1'b0;
    want_emit    = 1'b0;
    case (state_q)
      ST_PACK: begin
        want_emit    = (accept & (count_q == 4'd14)) | flush_req | end_req;
        flush_pend_d = flush_req & ~out_free;
        if (end_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        want_emit = 1'b1;
        if (out_free && count_q == '0) state_d = ST_DONE;
      end
      default: state_d = ST_DONE;
    endcase
    emit = want_emit & out_free & (cnt_next != '0);

    buffer_d = emit ? '0 : buf_next;
    count_d  = emit ? '0 : cnt_next;

    test_ending_d    = (state_d == ST_DRAIN);
    test_has_ended_d = (state_d == ST_DONE);

    drop_count_d = drop_count_q;
    if (dct_valid && !dct_ready && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_PACK;
      buffer_q         <= '0;
      count_q          <= '0;
      flush_pend_q     <= 1'b0;
      test_ending_q    <= 1'b0;
      test_has_ended_q <= 1'b0;
      drop_count_q     <= '0;
    end else begin
      state_q          <= state_d;
      buffer_q         <= buffer_d;
      count_q          <= count_d;
      flush_pend_q     <= flush_pend_d;
      test_ending_q    <= test_ending_d;
      test_has_ended_q <= test_has_ended_d;
      drop_count_q     <= drop_count_d;
    end
  end

  oci_frame_skid #(.W(FRAME_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (emit),
    .in_data   (pack_frame(FRAME_TYPE, cnt_next, buf_next)),
    .in_ready  (out_free),
    .out_valid (frame_valid),
    .out_data  (frame_data),
    .out_ready (frame_ready)
  );

  assign dct_buffer     = buffer_q;
  assign dct_count      = count_q;
  assign test_ending    = test_ending_q;
  assign test_has_ended = test_has_ended_q;
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_sys_nios2_qsys_0_oci_dct_packer.sv
// Scoreboard bench for the DCT packer: expected frames are queued as stimulus is driven
// and compared when the output handshake fires.
module tb_sys_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        dct_valid;
  logic [1:0]  dct_code;
  logic        dct_ready;
  logic        flush;
  logic        end_req;
  logic        frame_valid;
  logic [35:0] frame_data;
  logic        frame_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
  logic [15:0] drop_count;

  int          checks   = 0;
  int          failures = 0;
  logic [35:0] exp_q[$];
  logic [15:0] exp_drops = 16'd0;

  always #5 clk = ~clk;

  sys_nios2_qsys_0_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .dct_valid      (dct_valid),
    .dct_code       (dct_code),
    .dct_ready      (dct_ready),
    .flush          (flush),
    .end_req        (end_req),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .frame_ready    (frame_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .drop_count     (drop_count)
  );

  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [35:0] exp_frame(input logic [3:0] cnt, input logic [29:0] buffer);
    return {2'b10, cnt, buffer};
  endfunction

  // Drive one cycle of inputs, then return #1 after the sampling edge.
  task automatic apply_stimulus(input logic v, input logic [1:0] code, input logic f);
    dct_valid = v;
    dct_code  = code;
    flush     = f;
    @(posedge clk);
    #1;
    dct_valid = 1'b0;
    dct_code  = 2'b00;
    flush     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 2'b00, 1'b0);
  endtask

  // Every accepted frame is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) check_output("unexpected_frame", 64'(frame_data), 64'd0);
      else check_output("frame", 64'(frame_data), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; dct_valid = 1'b0; dct_code = 2'b00; flush = 1'b0;
    end_req = 1'b0; frame_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check_output("rst_count", 64'(dct_count), 64'd0);
    check_output("rst_buffer", 64'(dct_buffer), 64'd0);
    check_output("rst_frame_valid", 64'(frame_valid), 64'd0);
    check_output("rst_ready", 64'(dct_ready), 64'd1);
    check_output("rst_drops", 64'(drop_count), 64'd0);

    // Full buffer of taken branches.
    exp_q.push_back(exp_frame(4'd15, 30'h15555555));
    for (int i = 0; i < 14; i++) apply_stimulus(1'b1, 2'b01, 1'b0);
    check_output("full_count14", 64'(dct_count), 64'd14);
    apply_stimulus(1'b1, 2'b01, 1'b0);
    check_output("full_count_clear", 64'(dct_count), 64'd0);
    check_output("full_frame_valid", 64'(frame_valid), 64'd1);
    idle(2);

    // Partial buffer flush, then a flush with nothing held.
    exp_q.push_back(exp_frame(4'd3, 30'h11));
    apply_stimulus(1'b1, 2'b01, 1'b0);
    apply_stimulus(1'b1, 2'b00, 1'b0);
    apply_stimulus(1'b1, 2'b01, 1'b0);
    check_output("partial_buffer", 64'(dct_buffer), 64'h11);
    apply_stimulus(1'b0, 2'b00, 1'b1);
    idle(2);
    apply_stimulus(1'b0, 2'b00, 1'b1);
    idle(3);
    check_output("sb_after_flush", 64'(exp_q.size()), 64'd0);

    // Output blocked: buffer fills to 14 and extra codes are dropped.
    frame_ready = 1'b0;
    exp_q.push_back(exp_frame(4'd2, 30'h5));
    apply_stimulus(1'b1, 2'b01, 1'b0);
    apply_stimulus(1'b1, 2'b01, 1'b0);
    apply_stimulus(1'b0, 2'b00, 1'b1);
    check_output("blocked_valid", 64'(frame_valid), 64'd1);
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 2'b10, 1'b0);
    exp_drops = exp_drops + 16'd2;
    check_output("blocked_count", 64'(dct_count), 64'd14);
    check_output("blocked_ready", 64'(dct_ready), 64'd0);
    check_output("blocked_drops", 64'(drop_count), 64'(exp_drops));
    exp_q.push_back(exp_frame(4'd15, 30'h2AAAAAAA));
    frame_ready = 1'b1;
    dct_valid = 1'b1; dct_code = 2'b10;
    #1;
    check_output("release_ready", 64'(dct_ready), 64'd1);
    @(posedge clk);
    #1;
    dct_valid = 1'b0;
    idle(3);
    check_output("sb_after_block", 64'(exp_q.size()), 64'd0);

    // Code and flush in the same cycle at count 5.
    exp_q.push_back(exp_frame(4'd6, 30'hC00));
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 2'b00, 1'b0);
    apply_stimulus(1'b1, 2'b11, 1'b1);
    check_output("codeflush_count", 64'(dct_count), 64'd0);
    idle(2);

    // Flush arriving while the output is blocked is remembered.
    frame_ready = 1'b0;
    exp_q.push_back(exp_frame(4'd1, 30'h1));
    apply_stimulus(1'b1, 2'b01, 1'b1);
    apply_stimulus(1'b1, 2'b00, 1'b0);
    apply_stimulus(1'b1, 2'b00, 1'b0);
    apply_stimulus(1'b0, 2'b00, 1'b1);
    idle(1);
    check_output("latched_ready", 64'(dct_ready), 64'd0);
    check_output("latched_count", 64'(dct_count), 64'd2);
    exp_q.push_back(exp_frame(4'd2, 30'h0));
    frame_ready = 1'b1;
    idle(3);
    check_output("sb_after_latch", 64'(exp_q.size()), 64'd0);
    check_output("latched_clear", 64'(dct_count), 64'd0);

    // End of test with 7 codes held.
    for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 2'b01, 1'b0);
    exp_q.push_back(exp_frame(4'd7, 30'h1555));
    end_req = 1'b1;
    idle(1);
    check_output("ending", 64'(test_ending), 64'd1);
    check_output("ending_ready", 64'(dct_ready), 64'd0);
    for (int i = 0; i < 20 && !test_has_ended; i++) idle(1);
    check_output("has_ended", 64'(test_has_ended), 64'd1);
    check_output("ended_not_ending", 64'(test_ending), 64'd0);
    end_req = 1'b0;
    apply_stimulus(1'b1, 2'b01, 1'b0);
    exp_drops = exp_drops + 16'd1;
    idle(2);
    check_output("ended_sticky", 64'(test_has_ended), 64'd1);
    check_output("ended_ready", 64'(dct_ready), 64'd0);
    check_output("ended_drops", 64'(drop_count), 64'(exp_drops));
    check_output("sb_after_end", 64'(exp_q.size()), 64'd0);

    // Reset while a frame is pending and the buffer is part full.
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    frame_ready = 1'b0;
    apply_stimulus(1'b1, 2'b01, 1'b1);
    for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 2'b11, 1'b0);
    check_output("pre_rst_count", 64'(dct_count), 64'd9);
    check_output("pre_rst_valid", 64'(frame_valid), 64'd1);
    reset = 1'b1;
    idle(1);
    check_output("mid_rst_count", 64'(dct_count), 64'd0);
    check_output("mid_rst_buffer", 64'(dct_buffer), 64'd0);
    check_output("mid_rst_valid", 64'(frame_valid), 64'd0);
    check_output("mid_rst_data", 64'(frame_data), 64'd0);
    check_output("mid_rst_ended", 64'({test_ending, test_has_ended}), 64'd0);
    check_output("mid_rst_drops", 64'(drop_count), 64'd0);
    reset = 1'b0;
    frame_ready = 1'b1;
    idle(2);
    check_output("sb_final", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
